div16_seq: RTL and testbench



---
 rtl/div16_seq_pkg.sv | 15 +
 rtl/RCAD.sv | 23 ++
 rtl/div16_seq.sv | 93 +++++++++
 tb/tb_div16_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div16_seq_pkg.sv
// Shared constants and state encoding for the sequential 16-bit divider.
package div16_seq_pkg;

    localparam int W    = 16;
    localparam int ITER = 16;

    localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCAD.sv
// 16-bit ripple borrow-chain subtractor: diff = a - b - cin, cout is the borrow out.
module RCAD
    import div16_seq_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] diff,
    output logic         cout
);

    logic [W:0] brw;

    assign brw[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ brw[i];
        assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign cout = brw[W];

endmodule

// File: rtl/div16_seq.sv
// Restoring unsigned 16/16 divider, one quotient bit per clock, sharing one RCAD.
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | 16 shift/subtract/restore iterations
//   DONE  | one-cycle done pulse, results valid
module div16_seq
    import div16_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    state_t state, state_nxt;

    logic [W-1:0] q_reg, r_reg, d_reg;
    logic [3:0]   cnt;
    logic [W-1:0] p, diff, q_nxt, r_nxt;
    logic         borrow;

    // R[15] stays 0 between iterations, so the shifted partial remainder fits in W bits.
    assign p     = {r_reg[W-2:0], q_reg[W-1]};
    assign q_nxt = {q_reg[W-2:0], ~borrow};
    assign r_nxt = borrow ? p : diff;

    RCAD u_sub (
        .a    (p),
        .b    (d_reg),
        .cin  (1'b0),
        .diff (diff),
        .cout (borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            if (divisor != '0) begin
                q_reg <= dividend;
                d_reg <= divisor;
                r_reg <= '0;
                cnt   <= '0;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            q_reg <= q_nxt;
            r_reg <= r_nxt;
            cnt   <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Randomised scoreboard bench for div16_seq; expected results come from / and %.
module tb_div16_seq;

    logic        clk, rst_b, start;
    logic [15:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    div16_seq dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    logic [15:0] last_q = '0;
    logic [15:0] last_r = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer division, latency counted from the drive cycle.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.q         = (b == 0) ? 16'hFFFF : a / b;
        e.r         = (b == 0) ? a : a % b;
        e.dbz       = (b == 0);
        e.start_cyc = cyc;
        e.done_cyc  = cyc + ((b == 0) ? 1 : 17);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'((sb.size() > 0) && (cyc > sb[0].start_cyc)));
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    last_q = e.q;
                    last_r = e.r;
                end
            end else begin
                if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
                    check("missing_done", 32'(done), 32'd1);
                    void'(sb.pop_front());
                end
                check("quotient_hold", 32'(quotient), 32'(last_q));
                check("remainder_hold", 32'(remainder), 32'(last_r));
            end
        end
    end

    task automatic do_div(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push_exp(a, b);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0) begin
            @(negedge clk); #1;
            n++;
            if (n > 60) begin
                check("idle_timeout", 32'(n), 32'd60);
                sb.delete();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    logic [15:0] dir_a [7] = '{16'd100, 16'hFFFF, 16'h8000, 16'd5, 16'hFFFF, 16'h1234, 16'd10};
    logic [15:0] dir_b [7] = '{16'd7,   16'd1,    16'd3,    16'd9, 16'h8001, 16'd0,    16'd3};

    initial begin
        rst_b    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_b  = 1'b1;
        mon_en = 1;

        for (int i = 0; i < 7; i++) begin
            do_div(dir_a[i], dir_b[i]);
            wait_idle();
        end

        // A start pulse mid-run must be dropped.
        do_div(16'd100, 16'd7);
        repeat (6) @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset mid-run discards the partial result.
        do_div(16'd100, 16'd7);
        repeat (8) @(negedge clk);
        #1;
        rst_b = 1'b0;
        sb.delete();
        last_q = '0;
        last_r = '0;
        @(negedge clk); #1;
        check_reset_outputs("midrun_reset");
        rst_b = 1'b1;
        do_div(16'd20, 16'd6);
        wait_idle();

        // start held high: one operation every 18 cycles.
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            start    = 1'b1;
            dividend = 16'($urandom);
            divisor  = 16'($urandom_range(1, 65535));
            push_exp(dividend, divisor);
            if (i < 2) begin
                repeat (18) @(negedge clk);
                #1;
            end else begin
                @(negedge clk); #1;
                start = 1'b0;
            end
        end
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            logic [15:0] a, b;
            int sel;
            sel = int'($urandom_range(0, 7));
            a   = 16'($urandom);
            if (sel == 0)      b = '0;
            else if (sel < 3)  b = 16'($urandom_range(1, 15));
            else               b = 16'($urandom);
            do_div(a, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
